phase_sequencer: RTL and testbench

- Upstream controller for the second-granularity delay timer. It runs a traffic-light phase cycle: it loads a per-phase delay, pulses start, waits for the timer's busy output to rise then fall, and advances to the next phase.
- Drives the north-south (NS) and east-west (EW) lamp outputs, and reports a stall error if the timer never acknowledges a start.

---
 rtl/phase_sequencer.sv | 168 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Traffic-light phase sequencer that drives a second-granularity delay timer.
// Define PHASE_SEQUENCER_ALL_RED_EN to insert all-red clearance phases after each yellow.
module phase_sequencer #(
  parameter logic [4:0] GREEN_SEC   = 5'd10,
  parameter logic [4:0] YELLOW_SEC  = 5'd3,
  parameter logic [4:0] ALL_RED_SEC = 5'd1,
  parameter int         ACK_TIMEOUT = 4,
  parameter int         MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       timer_busy,
  output logic       timer_start,
  output logic [4:0] timer_delay,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic       error
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_ERROR     = 3'd4;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_NS_G  = 3'd1;
  localparam logic [2:0] PH_NS_Y  = 3'd2;
  localparam logic [2:0] PH_EW_G  = 3'd3;
  localparam logic [2:0] PH_EW_Y  = 3'd4;
  localparam logic [2:0] PH_RED_A = 3'd5;
  localparam logic [2:0] PH_RED_B = 3'd6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

  logic [2:0] state;
  logic [2:0] target;
  logic [7:0] ack_cnt;
  logic [7:0] retry_cnt;

  function automatic logic [2:0] ns_lamp(input logic [2:0] ph);
    case (ph)
      PH_NS_G: return LAMP_G;
      PH_NS_Y: return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input logic [2:0] ph);
    case (ph)
      PH_EW_G: return LAMP_G;
      PH_EW_Y: return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [4:0] delay_for(input logic [2:0] ph);
    case (ph)
      PH_NS_G, PH_EW_G: return GREEN_SEC;
      PH_NS_Y, PH_EW_Y: return YELLOW_SEC;
      default:          return ALL_RED_SEC;
    endcase
  endfunction

  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    logic [2:0] nxt;
    case (ph)
`ifdef PHASE_SEQUENCER_ALL_RED_EN
      PH_NS_G:  nxt = PH_NS_Y;
      PH_NS_Y:  nxt = PH_RED_A;
      PH_RED_A: nxt = PH_EW_G;
      PH_EW_G:  nxt = PH_EW_Y;
      PH_EW_Y:  nxt = PH_RED_B;
      default:  nxt = PH_NS_G;
`else
      PH_NS_G:  nxt = PH_NS_Y;
      PH_NS_Y:  nxt = PH_EW_G;
      PH_EW_G:  nxt = PH_EW_Y;
      default:  nxt = PH_NS_G;
`endif
    endcase
    return nxt;
  endfunction

  // Handshake: timer_start is a one-cycle request issued only while timer_busy=0;
  // timer_busy rising acknowledges it, timer_busy falling marks the interval done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      target      <= PH_NS_G;
      ack_cnt     <= 8'd0;
      retry_cnt   <= 8'd0;
      timer_start <= 1'b0;
      timer_delay <= 5'd0;
      ns_light    <= LAMP_R;
      ew_light    <= LAMP_R;
      phase       <= PH_IDLE;
      error       <= 1'b0;
    end else begin
      timer_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (run && !error) begin
            target <= PH_NS_G;
            state  <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // A stale interval from before reset must drain before a new start.
          if (!timer_busy) begin
            timer_start <= 1'b1;
            phase       <= target;
            ns_light    <= ns_lamp(target);
            ew_light    <= ew_lamp(target);
            timer_delay <= delay_for(target);
            ack_cnt     <= 8'd0;
            state       <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (timer_busy) begin
            ack_cnt   <= 8'd0;
            retry_cnt <= 8'd0;
            state     <= ST_WAIT_DONE;
          end else if (ack_cnt == ACK_LAST) begin
            ack_cnt <= 8'd0;
            if (retry_cnt == RETRY_LIMIT) begin
              error    <= 1'b1;
              phase    <= PH_IDLE;
              ns_light <= LAMP_R;
              ew_light <= LAMP_R;
              state    <= ST_ERROR;
            end else begin
              // Re-pulse directly; the timeout window guarantees low cycles in between.
              retry_cnt   <= retry_cnt + 8'd1;
              timer_start <= 1'b1;
            end
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (!timer_busy) begin
            if (run) begin
              target <= next_phase(phase);
              state  <= ST_LAUNCH;
            end else begin
              phase    <= PH_IDLE;
              ns_light <= LAMP_R;
              ew_light <= LAMP_R;
              state    <= ST_IDLE;
            end
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized scoreboard bench for phase_sequencer with a behavioural timer model.
module tb_phase_sequencer;

  localparam int ACK_TIMEOUT = 4;
  localparam int EXP_W = 22;

  typedef struct packed {
    logic [2:0] ph;
    logic [4:0] dly;
    logic [2:0] ns;
    logic [2:0] ew;
    logic [7:0] gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       timer_busy = 1'b0;
  logic       timer_start;
  logic [4:0] timer_delay;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic       error;

  logic [EXP_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int n_pulse = 0;
  int order[$];

  // timer model controls
  int model_starts = 0;
  int ack_from = 0;
  logic never_ack = 1'b0;
  int pend = 0;
  int blen = 0;
  int bleft = 0;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .timer_busy(timer_busy),
    .timer_start(timer_start), .timer_delay(timer_delay),
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase), .error(error)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // behavioural timer: busy rises 2 cycles after an accepted start, lasts (delay+1)*10 cycles
  always @(posedge clk) begin
    if (timer_start) begin
      model_starts <= model_starts + 1;
      if (!never_ack && model_starts >= ack_from) begin
        pend <= 1;
        blen <= (int'(timer_delay) + 1) * 10;
      end
    end
    if (pend == 1) begin
      pend <= 0;
      timer_busy <= 1'b1;
      bleft <= blen;
    end else if (timer_busy) begin
      if (bleft <= 1) timer_busy <= 1'b0;
      else bleft <= bleft - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // reference model: phase tables straight from the phase definitions
  function automatic logic [EXP_W-1:0] mk(input int ph, input int gap);
    exp_t e;
    e.ph  = 3'(ph);
    e.dly = (ph == 1 || ph == 3) ? 5'd10 : (ph == 2 || ph == 4) ? 5'd3 : 5'd1;
    e.ns  = (ph == 1) ? 3'b001 : (ph == 2) ? 3'b010 : 3'b100;
    e.ew  = (ph == 3) ? 3'b001 : (ph == 4) ? 3'b010 : 3'b100;
    e.gap = 8'(gap);
    return e;
  endfunction

  // monitor: pops an expectation on every start pulse, checks invariants every cycle
  int cyc = 0;
  int last_cyc = 0;
  logic prev_start = 1'b0;
  logic prev_busy = 1'b0;
  logic track = 1'b0;
  logic [4:0] held_dly = 5'd0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      track = 1'b0;
    end else begin
      if (timer_start) begin
        n_pulse++;
        chk("start_while_busy", timer_busy, 0);
        chk("start_single", prev_start, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          e = exp_t'(exp_q.pop_front());
          chk("phase", phase, e.ph);
          chk("delay", timer_delay, e.dly);
          chk("ns_light", ns_light, e.ns);
          chk("ew_light", ew_light, e.ew);
          if (e.gap != 0) chk("retry_gap", cyc - last_cyc, e.gap);
        end
        last_cyc = cyc;
        track = 1'b1;
        held_dly = timer_delay;
      end
      if (track && prev_busy && !timer_busy) begin
        chk("delay_stable", timer_delay, held_dly);
        track = 1'b0;
      end
      chk("ns_nonzero", (ns_light != 3'b000), 1);
      chk("ew_nonzero", (ew_light != 3'b000), 1);
      chk("one_axis_moving", (ns_light == 3'b100 || ew_light == 3'b100), 1);
`ifndef PHASE_SEQUENCER_ALL_RED_EN
      chk("phase_code_range", (phase <= 3'd4), 1);
`endif
    end
    prev_start = timer_start;
    prev_busy = timer_busy;
  end

  // driver tasks
  task automatic wait_pulses(input int target, input int budget);
    int n = 0;
    while (n_pulse < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pulses_in_time", (n_pulse >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (phase != 3'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_phase", phase, 0);
    chk("idle_ns_red", ns_light, 3'b100);
    chk("idle_ew_red", ew_light, 3'b100);
  endtask

  task automatic push_cycle(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(mk(order[i % order.size()], 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    int base;
    int nphase;
`ifdef PHASE_SEQUENCER_ALL_RED_EN
    order = '{1, 2, 5, 3, 4, 6};
`else
    order = '{1, 2, 3, 4};
`endif

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_start", timer_start, 0);
    chk("rst_delay", timer_delay, 0);
    chk("rst_error", error, 0);
    chk("rst_phase", phase, 0);
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);

    // run one phase, drop run during NS_G: phase completes then idle
    base = n_pulse;
    push_cycle(1);
    run = 1'b1;
    wait_pulses(base + 1, 50);
    repeat ($urandom_range(1, 30)) @(negedge clk);
    run = 1'b0;
    wait_idle(400);
    chk("drop_q_empty", exp_q.size(), 0);

    // free run for a random number of phases, resuming at NS_G
    for (int r = 0; r < 2; r++) begin
      nphase = (r == 0) ? order.size() + 1 : $urandom_range(2, 9);
      base = n_pulse;
      push_cycle(nphase);
      run = 1'b1;
      wait_pulses(base + nphase, 3000);
      repeat ($urandom_range(1, 20)) @(negedge clk);
      run = 1'b0;
      wait_idle(400);
      chk("run_q_empty", exp_q.size(), 0);
      chk("run_error", error, 0);
    end

    // timer ignores the first k pulses: re-pulses spaced ACK_TIMEOUT apart
    k = $urandom_range(1, 3);
    ack_from = model_starts + k;
    base = n_pulse;
    exp_q.push_back(mk(1, 0));
    for (int i = 0; i < k; i++) exp_q.push_back(mk(1, ACK_TIMEOUT));
    run = 1'b1;
    wait_pulses(base + k + 1, 100);
    run = 1'b0;
    wait_idle(400);
    chk("retry_error", error, 0);
    chk("retry_q_empty", exp_q.size(), 0);

    // timer never acknowledges: 4 pulses then sticky error
    never_ack = 1'b1;
    exp_q.push_back(mk(1, 0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, ACK_TIMEOUT));
    run = 1'b1;
    for (int n = 0; n < 100 && !error; n++) @(negedge clk);
    chk("stall_error", error, 1);
    chk("stall_phase", phase, 0);
    chk("stall_ns", ns_light, 3'b100);
    chk("stall_ew", ew_light, 3'b100);
    repeat (40) @(negedge clk);
    chk("stall_hold_phase", phase, 0);
    chk("stall_hold_error", error, 1);
    chk("stall_q_empty", exp_q.size(), 0);
    run = 1'b0;
    never_ack = 1'b0;
    do_reset();
    @(negedge clk);
    chk("stall_rst_error", error, 0);

    // reset during EW_Y while the timer is busy; no start until busy drains
    k = 0;
    while (order[k] != 4) k++;
    base = n_pulse;
    push_cycle(k + 1);
    run = 1'b1;
    wait_pulses(base + k + 1, 3000);
    for (int n = 0; n < 20 && !timer_busy; n++) @(negedge clk);
    chk("ewy_busy", timer_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_phase", phase, 0);
    chk("midrst_ns", ns_light, 3'b100);
    chk("midrst_ew", ew_light, 3'b100);
    chk("midrst_start", timer_start, 0);
    @(negedge clk);
    rst = 1'b0;
    base = n_pulse;
    exp_q.push_back(mk(1, 0));
    wait_pulses(base + 1, 400);
    run = 1'b0;
    wait_idle(400);
    chk("final_q_empty", exp_q.size(), 0);
    chk("final_error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
